// File: rtl/execute_mdu.sv
// execute_mdu: RV32 execute stage. It has a one-cycle ALU and branch path,
// NUM_FWD-way operand forwarding, and an optional multi-cycle multiply/divide
// unit. The MDU is built only when EXECUTE_MDU_EN is defined. Without that
// macro, busy is tied low and M ops retire with alu_result = 0.
module execute_mdu #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int MUL_LATENCY = 2,
    parameter int FW          = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [XLEN-1:0]         r1_data,
    input  logic [XLEN-1:0]         r2_data,
    input  logic [XLEN-1:0]         imm,
    input  logic [XLEN-1:0]         pc,
    input  logic [3:0]              alucode,
    input  logic                    using_r2,
    input  logic                    using_pc,
    input  logic                    is_md,
    input  logic [2:0]              mdcode,
    input  logic [FW-1:0]           fwd_sel1,
    input  logic [FW-1:0]           fwd_sel2,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    input  logic                    write_reg,
    input  logic [2:0]              info_load,
    input  logic [1:0]              info_store,
    input  logic [3:0]              info_branch,
    input  logic [4:0]              dstreg_addr,
    output logic                    busy,
    output logic                    branch_signal,
    output logic [XLEN-1:0]         branch_pc,
    output logic [XLEN-1:0]         alu_result,
    output logic [XLEN-1:0]         rs2E,
    output logic                    write_regE,
    output logic [2:0]              info_loadE,
    output logic [1:0]              info_storeE,
    output logic [4:0]              dstreg_addrE
);

    localparam int SHW = $clog2(XLEN);

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Branch kind encodings carried in info_branch
    localparam logic [3:0] BR_BEQ   = 4'd1;
    localparam logic [3:0] BR_BNE   = 4'd2;
    localparam logic [3:0] BR_BLT   = 4'd3;
    localparam logic [3:0] BR_BGE   = 4'd4;
    localparam logic [3:0] BR_BLTU  = 4'd5;
    localparam logic [3:0] BR_BGEU  = 4'd6;
    localparam logic [3:0] BR_BJAL  = 4'd7;
    localparam logic [3:0] BR_BJALR = 4'd8;

    logic [XLEN-1:0] fwd1, fwd2, opa, opb, alu_out, nonmd_result;
    logic            br_take, is_jump;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    // Forwarding mux. Select 0 and any out-of-range select use the register value.
    always_comb begin
        fwd1 = r1_data;
        fwd2 = r2_data;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (int'(fwd_sel1) == k) fwd1 = fwd_data[k*XLEN-1 -: XLEN];
            if (int'(fwd_sel2) == k) fwd2 = fwd_data[k*XLEN-1 -: XLEN];
        end
    end

    assign opa = using_pc ? pc : fwd1;
    assign opb = using_r2 ? fwd2 : imm;

    // Single-cycle ALU
    always_comb begin
        alu_out = '0;
        case (alucode)
            ALU_ADD:   alu_out = opa + opb;
            ALU_SUB:   alu_out = opa - opb;
            ALU_SLL:   alu_out = opa << opb[SHW-1:0];
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (opa < opb)};
            ALU_XOR:   alu_out = opa ^ opb;
            ALU_SRL:   alu_out = opa >> opb[SHW-1:0];
            ALU_SRA:   alu_out = $signed(opa) >>> opb[SHW-1:0];
            ALU_OR:    alu_out = opa | opb;
            ALU_AND:   alu_out = opa & opb;
            ALU_PASSB: alu_out = opb;
            default:   alu_out = '0;
        endcase
    end

    // Branch comparator. It compares the forwarded rs1/rs2 values, not the
    // ALU operands, because the ALU is busy computing pc+imm.
    always_comb begin
        br_take = 1'b0;
        case (info_branch)
            BR_BEQ:   br_take = (fwd1 == fwd2);
            BR_BNE:   br_take = (fwd1 != fwd2);
            BR_BLT:   br_take = ($signed(fwd1) <  $signed(fwd2));
            BR_BGE:   br_take = ($signed(fwd1) >= $signed(fwd2));
            BR_BLTU:  br_take = (fwd1 <  fwd2);
            BR_BGEU:  br_take = (fwd1 >= fwd2);
            BR_BJAL,
            BR_BJALR: br_take = 1'b1;
            default:  br_take = 1'b0;
        endcase
    end

    assign branch_signal = br_take & ~flush;
    assign branch_pc     = alu_out;
    assign is_jump       = (info_branch == BR_BJAL) || (info_branch == BR_BJALR);
    assign nonmd_result  = is_jump ? (pc + XLEN'(4)) : alu_out;

`ifdef EXECUTE_MDU_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

    localparam int CMAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CW   = $clog2(CMAX + 1);

    md_state_e       state, state_nx;
    logic            start;
    logic [CW-1:0]   cnt;
    logic [2:0]      md_op;
    logic [XLEN-1:0] a_raw, b_raw, a_mag, b_mag, quo, rem;
    logic            a_neg, b_neg;

    // Signedness of each operand, decoded from the incoming funct3
    logic            a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    assign a_sgn_in = (mdcode == 3'd1) || (mdcode == 3'd2) || (mdcode == 3'd4) || (mdcode == 3'd6);
    assign b_sgn_in = (mdcode == 3'd1) || (mdcode == 3'd4) || (mdcode == 3'd6);
    assign a_neg_in = a_sgn_in & fwd1[XLEN-1];
    assign b_neg_in = b_sgn_in & fwd2[XLEN-1];

    // MDU state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and stall request
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        start    = 1'b0;
        case (state)
            S_IDLE: if (is_md && !flush) begin
                busy     = 1'b1;
                start    = 1'b1;
                state_nx = mdcode[2] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                busy = 1'b1;
                if (flush)                               state_nx = S_IDLE;
                else if (cnt == CW'(MUL_LATENCY - 1))    state_nx = S_DONE;
            end
            S_DIV: begin
                busy = 1'b1;
                if (flush)                               state_nx = S_IDLE;
                else if (cnt == CW'(XLEN - 1))           state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch and restoring divider. The quotient is shifted into quo
    // as the dividend bits are shifted out of it.
    logic [XLEN:0] shifted, diff;
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, b_mag};

    // MDU datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            md_op <= '0;
            a_raw <= '0;
            b_raw <= '0;
            a_mag <= '0;
            b_mag <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            quo   <= '0;
            rem   <= '0;
        end else if (start) begin
            cnt   <= '0;
            md_op <= mdcode;
            a_raw <= fwd1;
            b_raw <= fwd2;
            a_mag <= a_neg_in ? -fwd1 : fwd1;
            b_mag <= b_neg_in ? -fwd2 : fwd2;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            quo   <= a_neg_in ? -fwd1 : fwd1;
            rem   <= '0;
        end else if (state == S_MUL || state == S_DIV) begin
            cnt <= cnt + 1'b1;
            if (state == S_DIV) begin
                if (!diff[XLEN]) begin
                    rem <= diff[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem <= shifted[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Result assembly in DONE: signs are reapplied and the special divide
    // cases are handled explicitly.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   q_s, r_s;
    logic              div_zero, div_ovf;
    assign prod     = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign prod_s   = (a_neg ^ b_neg) ? -prod : prod;
    assign q_s      = (a_neg ^ b_neg) ? -quo : quo;
    assign r_s      = a_neg ? -rem : rem;
    assign div_zero = (b_raw == '0);
    assign div_ovf  = ((md_op == 3'd4) || (md_op == 3'd6)) &&
                      (a_raw == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw == '1);

    // Select the MD result by operation
    always_comb begin
        md_result = '0;
        case (md_op)
            3'd0:         md_result = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         md_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:   md_result = div_zero ? '1 : (div_ovf ? a_raw : q_s);
            default:      md_result = div_zero ? a_raw : (div_ovf ? '0 : r_s);
        endcase
    end

    assign md_done = (state == S_DONE);
`else
    // Without the MDU, M ops fall through the one-cycle path with a zero result.
    logic unused_mdcode;
    assign unused_mdcode = ^mdcode;
    assign busy          = 1'b0;
    assign md_done       = 1'b0;
    assign md_result     = '0;
`endif

    // Pipeline output registers. A flush or stall loads a bubble and leaves
    // alu_result holding its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result   <= '0;
            rs2E         <= '0;
            write_regE   <= 1'b0;
            info_loadE   <= '0;
            info_storeE  <= '0;
            dstreg_addrE <= '0;
        end else if (flush || busy) begin
            write_regE   <= 1'b0;
            info_loadE   <= '0;
            info_storeE  <= '0;
            dstreg_addrE <= '0;
        end else begin
            alu_result   <= md_done ? md_result : (is_md ? '0 : nonmd_result);
            rs2E         <= fwd2;
            write_regE   <= write_reg;
            info_loadE   <= info_load;
            info_storeE  <= info_store;
            dstreg_addrE <= dstreg_addr;
        end
    end

endmodule
